// File: rtl/uart_reg_responder.sv
// Byte-command responder: 'W' addr data writes, 'R' addr reads a 4x8 register bank, one response byte per command.
// o_Tx_DV rises the cycle after the final command byte unless the transmitter is busy; bytes arriving while a response is pending are dropped.
module uart_reg_responder #(
    parameter int          TIMEOUT_CLKS = 50000,
    parameter logic [7:0]  ACK_BYTE     = 8'h06,
    parameter logic [7:0]  NAK_BYTE     = 8'h15
) (
    input  logic        i_Clock,
    input  logic        KEY_rst,
    input  logic        i_Rx_DV,
    input  logic [7:0]  i_Rx_Byte,
    input  logic        i_Tx_Active,
    input  logic        i_Tx_Done,
    output logic        o_Tx_DV,
    output logic [7:0]  o_Tx_Byte,
    output logic [31:0] o_Regs,
    output logic        o_Busy,
    output logic        o_Drop
);

    localparam int             CW      = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]     OP_W    = 8'h57;
    localparam logic [7:0]     OP_R    = 8'h52;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_SEND,
        S_WAIT_DONE
    } state_t;

    state_t           r_state;
    logic             r_is_write;
    logic [7:0]       r_addr;
    logic [3:0][7:0]  r_regs;
    logic [7:0]       r_tx_byte;
    logic             r_busy;
    logic             r_drop;
    logic [CW-1:0]    r_cnt;

    state_t           w_next_state;
    logic             w_load_tx;
    logic [7:0]       w_tx_byte;
    logic             w_reg_we;
    logic [CW-1:0]    w_cnt_next;
    logic             w_drop;
    logic             w_latch_op;
    logic             w_latch_addr;
    logic             w_rx_addr_ok;
    logic             w_addr_ok;

    assign w_rx_addr_ok = (i_Rx_Byte[7:2] == 6'd0);
    assign w_addr_ok    = (r_addr[7:2] == 6'd0);

    always_comb begin
        w_next_state = r_state;
        w_load_tx    = 1'b0;
        w_tx_byte    = r_tx_byte;
        w_reg_we     = 1'b0;
        w_cnt_next   = '0;
        w_drop       = 1'b0;
        w_latch_op   = 1'b0;
        w_latch_addr = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte == OP_W || i_Rx_Byte == OP_R) begin
                        w_latch_op   = 1'b1;
                        w_next_state = S_GET_ADDR;
                    end else begin
                        w_load_tx    = 1'b1;
                        w_tx_byte    = NAK_BYTE;
                        w_next_state = S_SEND;
                    end
                end
            end
            S_GET_ADDR: begin
                if (i_Rx_DV) begin
                    w_latch_addr = 1'b1;
                    if (r_is_write) begin
                        w_next_state = S_GET_DATA;
                    end else begin
                        w_load_tx    = 1'b1;
                        w_tx_byte    = w_rx_addr_ok ? r_regs[i_Rx_Byte[1:0]] : NAK_BYTE;
                        w_next_state = S_SEND;
                    end
                end else if (r_cnt == TO_LAST) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_GET_DATA: begin
                // A byte arriving on the expiry cycle still completes the command.
                if (i_Rx_DV) begin
                    w_reg_we     = w_addr_ok;
                    w_load_tx    = 1'b1;
                    w_tx_byte    = w_addr_ok ? ACK_BYTE : NAK_BYTE;
                    w_next_state = S_SEND;
                end else if (r_cnt == TO_LAST) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_SEND: begin
                w_drop = i_Rx_DV;
                if (!i_Tx_Active) begin
                    w_next_state = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                w_drop = i_Rx_DV;
                if (i_Tx_Done) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge KEY_rst) begin
        if (!KEY_rst) begin
            r_state    <= S_IDLE;
            r_is_write <= 1'b0;
            r_addr     <= 8'd0;
            r_regs     <= '0;
            r_tx_byte  <= 8'd0;
            r_busy     <= 1'b0;
            r_drop     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != S_IDLE);
            r_drop  <= w_drop;
            r_cnt   <= w_cnt_next;
            if (w_latch_op) begin
                r_is_write <= (i_Rx_Byte == OP_W);
            end
            if (w_latch_addr) begin
                r_addr <= i_Rx_Byte;
            end
            if (w_reg_we) begin
                r_regs[r_addr[1:0]] <= i_Rx_Byte;
            end
            if (w_load_tx) begin
                r_tx_byte <= w_tx_byte;
            end
        end
    end

    // Combinational so the request appears in the first SEND cycle the transmitter is idle.
    assign o_Tx_DV   = (r_state == S_SEND) && !i_Tx_Active;
    assign o_Tx_Byte = r_tx_byte;
    assign o_Regs    = r_regs;
    assign o_Busy    = r_busy;
    assign o_Drop    = r_drop;

endmodule

// File: tb/tb_uart_reg_responder.sv
// Directed bench for uart_reg_responder: write/read, NAK paths, timeout, tx backpressure, drops, mid-command reset.
module tb_uart_reg_responder;

    logic        i_Clock;
    logic        KEY_rst;
    logic        i_Rx_DV;
    logic [7:0]  i_Rx_Byte;
    logic        i_Tx_Active;
    logic        i_Tx_Done;
    logic        o_Tx_DV;
    logic [7:0]  o_Tx_Byte;
    logic [31:0] o_Regs;
    logic        o_Busy;
    logic        o_Drop;

    int n_vec = 0;
    int n_err = 0;
    int tx_cnt = 0;
    int tx_base;

    uart_reg_responder #(
        .TIMEOUT_CLKS (20),
        .ACK_BYTE     (8'h06),
        .NAK_BYTE     (8'h15)
    ) dut (
        .i_Clock     (i_Clock),
        .KEY_rst     (KEY_rst),
        .i_Rx_DV     (i_Rx_DV),
        .i_Rx_Byte   (i_Rx_Byte),
        .i_Tx_Active (i_Tx_Active),
        .i_Tx_Done   (i_Tx_Done),
        .o_Tx_DV     (o_Tx_DV),
        .o_Tx_Byte   (o_Tx_Byte),
        .o_Regs      (o_Regs),
        .o_Busy      (o_Busy),
        .o_Drop      (o_Drop)
    );

    initial i_Clock = 1'b0;
    always #5 i_Clock = ~i_Clock;

    always @(posedge i_Clock) begin
        if (o_Tx_DV === 1'b1) tx_cnt++;
    end

    // All stimulus tasks start and end on a falling edge.
    task automatic send_byte(input logic [7:0] b);
        i_Rx_DV   = 1'b1;
        i_Rx_Byte = b;
        @(negedge i_Clock);
        i_Rx_DV   = 1'b0;
    endtask

    task automatic finish_tx(input int n);
        repeat (n) @(negedge i_Clock);
        i_Tx_Done = 1'b1;
        @(negedge i_Clock);
        i_Tx_Done = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge i_Clock);
        n_vec++; if (o_Regs !== 32'h0) begin n_err++; $display("FAIL rst_regs got %h want %h", o_Regs, 32'h0); end
        n_vec++; if (o_Busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", o_Busy); end
        n_vec++; if (o_Tx_DV !== 1'b0) begin n_err++; $display("FAIL rst_txdv got %b want 0", o_Tx_DV); end
        n_vec++; if (o_Tx_Byte !== 8'h00) begin n_err++; $display("FAIL rst_txbyte got %h want 00", o_Tx_Byte); end
        n_vec++; if (o_Drop !== 1'b0) begin n_err++; $display("FAIL rst_drop got %b want 0", o_Drop); end
        KEY_rst = 1'b1;
        @(negedge i_Clock);
    endtask

    task automatic test_write;
        tx_base = tx_cnt;
        send_byte(8'h57);
        n_vec++; if (o_Busy !== 1'b1) begin n_err++; $display("FAIL wr_busy got %b want 1", o_Busy); end
        send_byte(8'h02);
        n_vec++; if (o_Regs !== 32'h0) begin n_err++; $display("FAIL wr_early got %h want %h", o_Regs, 32'h0); end
        send_byte(8'hA5);
        n_vec++; if (o_Regs !== 32'h00A5_0000) begin n_err++; $display("FAIL wr_regs got %h want %h", o_Regs, 32'h00A5_0000); end
        n_vec++; if (o_Tx_DV !== 1'b1) begin n_err++; $display("FAIL wr_txdv got %b want 1", o_Tx_DV); end
        n_vec++; if (o_Tx_Byte !== 8'h06) begin n_err++; $display("FAIL wr_ack got %h want 06", o_Tx_Byte); end
        @(negedge i_Clock);
        n_vec++; if (o_Tx_DV !== 1'b0) begin n_err++; $display("FAIL wr_txdv_one got %b want 0", o_Tx_DV); end
        n_vec++; if (o_Busy !== 1'b1) begin n_err++; $display("FAIL wr_busy_wait got %b want 1", o_Busy); end
        finish_tx(9);
        n_vec++; if (o_Busy !== 1'b0) begin n_err++; $display("FAIL wr_idle got %b want 0", o_Busy); end
        n_vec++; if (tx_cnt - tx_base !== 1) begin n_err++; $display("FAIL wr_txcnt got %0d want 1", tx_cnt - tx_base); end
    endtask

    task automatic test_readback;
        logic [7:0] addr_v [3];
        logic [7:0] exp_v  [3];
        addr_v = '{8'h02, 8'h00, 8'h03};
        exp_v  = '{8'hA5, 8'h00, 8'h00};
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h52);
            send_byte(addr_v[i]);
            n_vec++; if (o_Tx_DV !== 1'b1) begin n_err++; $display("FAIL rd_txdv[%0d] got %b want 1", i, o_Tx_DV); end
            n_vec++; if (o_Tx_Byte !== exp_v[i]) begin n_err++; $display("FAIL rd_data[%0d] got %h want %h", i, o_Tx_Byte, exp_v[i]); end
            finish_tx(2);
        end
    endtask

    task automatic test_errors;
        send_byte(8'h41);
        n_vec++; if (o_Tx_DV !== 1'b1) begin n_err++; $display("FAIL badop_txdv got %b want 1", o_Tx_DV); end
        n_vec++; if (o_Tx_Byte !== 8'h15) begin n_err++; $display("FAIL badop_nak got %h want 15", o_Tx_Byte); end
        n_vec++; if (o_Regs !== 32'h00A5_0000) begin n_err++; $display("FAIL badop_regs got %h want %h", o_Regs, 32'h00A5_0000); end
        finish_tx(2);
        send_byte(8'h57); send_byte(8'h07); send_byte(8'hFF);
        n_vec++; if (o_Tx_Byte !== 8'h15) begin n_err++; $display("FAIL wrbad_nak got %h want 15", o_Tx_Byte); end
        n_vec++; if (o_Regs !== 32'h00A5_0000) begin n_err++; $display("FAIL wrbad_regs got %h want %h", o_Regs, 32'h00A5_0000); end
        finish_tx(2);
        send_byte(8'h52); send_byte(8'h04);
        n_vec++; if (o_Tx_Byte !== 8'h15) begin n_err++; $display("FAIL rdbad_nak got %h want 15", o_Tx_Byte); end
        finish_tx(2);
    endtask

    task automatic test_timeout;
        tx_base = tx_cnt;
        send_byte(8'h57); send_byte(8'h01);
        repeat (19) @(negedge i_Clock);
        n_vec++; if (o_Busy !== 1'b1) begin n_err++; $display("FAIL to_busy_19 got %b want 1", o_Busy); end
        @(negedge i_Clock);
        n_vec++; if (o_Busy !== 1'b0) begin n_err++; $display("FAIL to_idle_20 got %b want 0", o_Busy); end
        repeat (5) @(negedge i_Clock);
        n_vec++; if (tx_cnt - tx_base !== 0) begin n_err++; $display("FAIL to_silent got %0d want 0", tx_cnt - tx_base); end
        send_byte(8'h52); send_byte(8'h01);
        n_vec++; if (o_Tx_Byte !== 8'h00) begin n_err++; $display("FAIL to_rd got %h want 00", o_Tx_Byte); end
        finish_tx(2);
        // Data byte lands on the expiry cycle: it must still be accepted.
        send_byte(8'h57); send_byte(8'h01);
        repeat (19) @(negedge i_Clock);
        send_byte(8'h5A);
        n_vec++; if (o_Tx_Byte !== 8'h06) begin n_err++; $display("FAIL to_edge_ack got %h want 06", o_Tx_Byte); end
        n_vec++; if (o_Regs !== 32'h00A5_5A00) begin n_err++; $display("FAIL to_edge_regs got %h want %h", o_Regs, 32'h00A5_5A00); end
        finish_tx(2);
    endtask

    task automatic test_backpressure;
        tx_base = tx_cnt;
        i_Tx_Active = 1'b1;
        send_byte(8'h52); send_byte(8'h02);
        n_vec++; if (o_Tx_DV !== 1'b0) begin n_err++; $display("FAIL bp_hold got %b want 0", o_Tx_DV); end
        repeat (3) @(negedge i_Clock);
        n_vec++; if (tx_cnt - tx_base !== 0) begin n_err++; $display("FAIL bp_held_cnt got %0d want 0", tx_cnt - tx_base); end
        n_vec++; if (o_Busy !== 1'b1) begin n_err++; $display("FAIL bp_busy got %b want 1", o_Busy); end
        i_Tx_Active = 1'b0;
        #1;
        n_vec++; if (o_Tx_DV !== 1'b1) begin n_err++; $display("FAIL bp_release got %b want 1", o_Tx_DV); end
        n_vec++; if (o_Tx_Byte !== 8'hA5) begin n_err++; $display("FAIL bp_data got %h want a5", o_Tx_Byte); end
        @(negedge i_Clock);
        n_vec++; if (o_Tx_DV !== 1'b0) begin n_err++; $display("FAIL bp_single got %b want 0", o_Tx_DV); end
        n_vec++; if (tx_cnt - tx_base !== 1) begin n_err++; $display("FAIL bp_cnt got %0d want 1", tx_cnt - tx_base); end
        send_byte(8'h57);
        n_vec++; if (o_Drop !== 1'b1) begin n_err++; $display("FAIL drop_pulse got %b want 1", o_Drop); end
        @(negedge i_Clock);
        n_vec++; if (o_Drop !== 1'b0) begin n_err++; $display("FAIL drop_single got %b want 0", o_Drop); end
        n_vec++; if (o_Busy !== 1'b1) begin n_err++; $display("FAIL drop_state got %b want 1", o_Busy); end
        // Done and a new byte together: the byte is dropped, the FSM goes idle.
        i_Tx_Done = 1'b1;
        send_byte(8'h41);
        i_Tx_Done = 1'b0;
        n_vec++; if (o_Drop !== 1'b1) begin n_err++; $display("FAIL done_drop got %b want 1", o_Drop); end
        n_vec++; if (o_Busy !== 1'b0) begin n_err++; $display("FAIL done_idle got %b want 0", o_Busy); end
        repeat (2) @(negedge i_Clock);
        n_vec++; if (tx_cnt - tx_base !== 1) begin n_err++; $display("FAIL drop_no_tx got %0d want 1", tx_cnt - tx_base); end
        n_vec++; if (o_Regs !== 32'h00A5_5A00) begin n_err++; $display("FAIL drop_regs got %h want %h", o_Regs, 32'h00A5_5A00); end
    endtask

    task automatic test_reset_mid;
        tx_base = tx_cnt;
        send_byte(8'h57); send_byte(8'h00);
        KEY_rst = 1'b0;
        #2;
        n_vec++; if (o_Regs !== 32'h0) begin n_err++; $display("FAIL mid_regs got %h want %h", o_Regs, 32'h0); end
        n_vec++; if (o_Busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got %b want 0", o_Busy); end
        @(negedge i_Clock);
        KEY_rst = 1'b1;
        repeat (3) @(negedge i_Clock);
        n_vec++; if (tx_cnt - tx_base !== 0) begin n_err++; $display("FAIL mid_no_tx got %0d want 0", tx_cnt - tx_base); end
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h3C);
        n_vec++; if (o_Regs !== 32'h0000_003C) begin n_err++; $display("FAIL mid_wr got %h want %h", o_Regs, 32'h0000_003C); end
        n_vec++; if (o_Tx_Byte !== 8'h06) begin n_err++; $display("FAIL mid_ack got %h want 06", o_Tx_Byte); end
        finish_tx(2);
        n_vec++; if (tx_cnt - tx_base !== 1) begin n_err++; $display("FAIL mid_txcnt got %0d want 1", tx_cnt - tx_base); end
    endtask

    initial begin
        KEY_rst     = 1'b0;
        i_Rx_DV     = 1'b0;
        i_Rx_Byte   = 8'h00;
        i_Tx_Active = 1'b0;
        i_Tx_Done   = 1'b0;
        test_reset;
        test_write;
        test_readback;
        test_errors;
        test_timeout;
        test_backpressure;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_reg_responder.md
Name: uart_reg_responder

Overview:
- Command responder at the far end of the UART link; sits between the `uart_rx` byte interface and the `uart_tx` byte interface.
- Parses byte commands arriving from the receiver and executes register writes and reads on a 4x8-bit register bank.
- Returns one response byte per command through the transmitter handshake.
- The register bank drives board outputs, such as LEDR, at the top level.

Parameters:
- TIMEOUT_CLKS, default 50000, idle clocks allowed between bytes of one command before it is abandoned.
- ACK_BYTE, default 8'h06, response to a successful write.
- NAK_BYTE, default 8'h15, response to a bad opcode or address.

Ports:
- i_Clock  input  1  system clock; all logic is on the rising edge.
- KEY_rst  input  1  asynchronous active-low reset.
- i_Rx_DV  input  1  one-cycle strobe: i_Rx_Byte is valid.
- i_Rx_Byte  input  8  received byte.
- i_Tx_Active  input  1  transmitter busy serialising.
- i_Tx_Done  input  1  one-cycle strobe: transmitter finished its byte.
- o_Tx_DV  output  1  one-cycle request to send o_Tx_Byte.
- o_Tx_Byte  output  8  response byte; held stable from o_Tx_DV until i_Tx_Done.
- o_Regs  output  32  register bank; reg0 is at [7:0] and reg3 is at [31:24].
- o_Busy  output  1  high whenever the FSM is not in IDLE.
- o_Drop  output  1  one-cycle pulse when an incoming byte is discarded.

Behaviour:
- Reset (KEY_rst=0, asynchronous):
  - State goes to IDLE.
  - o_Regs, o_Tx_Byte, o_Tx_DV, o_Busy, o_Drop and the timeout counter all go to 0.
  - Release is recognised on the next i_Clock edge.
  - A reset during any state aborts the command; no response is sent.
- Command format, first byte is the opcode:
  - 8'h57 ('W'): followed by addr, then data.
  - 8'h52 ('R'): followed by addr.
  - Only addr[1:0] is used when addr < 4; addr >= 4 is invalid.
- State IDLE:
  - On i_Rx_DV with 'W' or 'R', latch the opcode and go to GET_ADDR.
  - On i_Rx_DV with any other byte, load NAK_BYTE and go to SEND.
- State GET_ADDR, on i_Rx_DV:
  - Latch the address.
  - If opcode is 'W', go to GET_DATA.
  - If opcode is 'R' and addr < 4, load o_Tx_Byte = reg[addr] and go to SEND.
  - If opcode is 'R' and addr >= 4, load NAK_BYTE and go to SEND.
- State GET_DATA, on i_Rx_DV:
  - If addr < 4, write reg[addr] = i_Rx_Byte; it is visible on o_Regs the next cycle. Load ACK_BYTE and go to SEND.
  - Otherwise leave the registers unchanged, load NAK_BYTE and go to SEND.
- Timeout (GET_ADDR and GET_DATA only):
  - The counter clears on every i_Rx_DV and increments on every other clock.
  - When it reaches TIMEOUT_CLKS-1 with no byte, return to IDLE silently with no response.
  - The counter is held at 0 in all other states.
- State SEND:
  - Wait while i_Tx_Active=1.
  - On the first cycle with i_Tx_Active=0, assert o_Tx_DV for exactly one cycle, then go to WAIT_DONE.
- State WAIT_DONE:
  - On i_Tx_Done go to IDLE; a new command is accepted on the following cycle.
  - There is no timeout in this state.
- Bytes arriving during SEND or WAIT_DONE are discarded and pulse o_Drop for one cycle. They never affect the registers or the state.
- Latency:
  - o_Tx_DV rises 1 cycle after the last command byte's i_Rx_DV, provided i_Tx_Active=0.
  - A read returns the register value as it stood at the addr byte.
- Simultaneous events:
  - i_Rx_DV and the timeout expiry in the same cycle: the byte wins; the counter clears and the byte is processed.
  - i_Tx_Done and i_Rx_DV in the same cycle in WAIT_DONE: the byte is dropped.
- o_Busy = (state != IDLE), registered.

Test Plan:
- Reset then write: 'W',8'h02,8'hA5 → o_Regs[23:16]=8'hA5 one cycle after the third strobe; exactly one o_Tx_DV with o_Tx_Byte=8'h06. Model i_Tx_Done 10 cycles later → o_Busy=0.
- Readback: after the write above, send 'R',8'h02 → o_Tx_Byte=8'hA5; other registers read 8'h00.
- Errors:
  - Opcode 8'h41 → NAK 8'h15 and no register change.
  - 'W',8'h07,8'hFF → NAK and o_Regs unchanged.
  - 'R',8'h04 → NAK.
- Timeout (TIMEOUT_CLKS=20): 'W',8'h01, then idle 25 cycles → back to IDLE with no o_Tx_DV. Then 'R',8'h01 → response 8'h00.
- Tx backpressure and drop:
  - Hold i_Tx_Active=1 across command completion → o_Tx_DV is withheld until i_Tx_Active falls, then pulses once.
  - An i_Rx_DV during WAIT_DONE → o_Drop pulses and the state is unaffected.
- Reset mid-command: 'W',8'h00, then pulse KEY_rst low → o_Regs=0, o_Busy=0, no o_Tx_DV. A following 'W',8'h00,8'h3C works normally.
